dvs_event_fifo: RTL and testbench

Parametrised DVS event FIFO that buffers packed address-event words (x, y, polarity, timestamp) between the sensor front end and the voxel-binning pipeline. It generalises the shallow event buffer with configurable field widths and depth, a valid/ready output, fill-level and almost-full reporting, a synchronous flush, and a lossy mode that drops and counts events instead of back-pressuring the sensor. Optional statistics (drop counter, high-water mark) support link-budget debugging.

---
 rtl/dvs_event_fifo.sv | 138 +++++++++++++
 tb/tb_dvs_event_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dvs_event_fifo.sv
// Purpose : buffers packed DVS address-events {x, y, pol, ts} between the sensor
//           front end and the voxel-binning pipeline.
// Latency : first-word fall-through; an event pushed at edge N is visible at the
//           output in cycle N+1.
// Backpr. : LOSSY=0 deasserts in_ready when full; LOSSY=1 never stalls and
//           discards (and counts) events that arrive while full.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid/in_ready, in_x/y/pol/ts input event handshake and fields
//   out_valid/out_ready, out_x/y/pol/ts head event handshake and fields
//   flush                            synchronous empty (pointers to 0)
//   level, almost_full               occupancy and level >= AFULL_THRESH
//   stats_clear, drop_count, hwm     drop counter and high-water mark
//
// Build option: define DVS_FIFO_STATS_EN to compile in the drop counter and
// high-water mark; otherwise drop_count and hwm are tied to 0.
module dvs_event_fifo #(
   parameter int X_BITS       = 9,
   parameter int Y_BITS       = 9,
   parameter int TS_BITS      = 16,
   parameter int DEPTH        = 16,
   parameter int AFULL_THRESH = 12,
   parameter int LOSSY        = 0,
   parameter int DROP_BITS    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [X_BITS-1:0]         in_x,
   input  logic [Y_BITS-1:0]         in_y,
   input  logic                      in_pol,
   input  logic [TS_BITS-1:0]        in_ts,
   output logic                      in_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [X_BITS-1:0]         out_x,
   output logic [Y_BITS-1:0]         out_y,
   output logic                      out_pol,
   output logic [TS_BITS-1:0]        out_ts,
   input  logic                      flush,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      almost_full,
   input  logic                      stats_clear,
   output logic [DROP_BITS-1:0]      drop_count,
   output logic [$clog2(DEPTH):0]    hwm
);

   localparam int PTR_BITS = $clog2(DEPTH);
   localparam int LVL_W    = PTR_BITS + 1;
   localparam int EW       = X_BITS + Y_BITS + 1 + TS_BITS;

   localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] AFULL_LVL = LVL_W'(AFULL_THRESH);

   logic [EW-1:0]    r_mem [0:DEPTH-1];
   logic [LVL_W-1:0] r_wr_ptr;
   logic [LVL_W-1:0] r_rd_ptr;

   logic [LVL_W-1:0] w_level;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_drop;
   logic [EW-1:0]    w_in_word;
   logic [EW-1:0]    w_head;

   // Pointers carry one extra MSB so full and empty are distinguishable;
   // the modular difference is the occupancy, wrap needs no special case.
   assign w_level = r_wr_ptr - r_rd_ptr;
   assign w_full  = (w_level == DEPTH_LVL);
   assign w_empty = (w_level == '0);

   assign in_ready    = (LOSSY != 0) ? 1'b1 : !w_full;
   assign out_valid   = !w_empty;
   assign level       = w_level;
   assign almost_full = (w_level >= AFULL_LVL);

   // Full is judged on the pre-edge state, so an arrival while full is not
   // rescued by a same-cycle pop. Flush suppresses push, pop and drop.
   assign w_push = in_valid && !w_full && !flush;
   assign w_pop  = out_valid && out_ready && !flush;
   assign w_drop = (LOSSY != 0) && in_valid && w_full && !flush;

   assign w_in_word = {in_x, in_y, in_pol, in_ts};
   assign w_head    = r_mem[r_rd_ptr[PTR_BITS-1:0]];
   assign {out_x, out_y, out_pol, out_ts} = w_head;

   // Storage is deliberately not reset; only pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[PTR_BITS-1:0]] <= w_in_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

`ifdef DVS_FIFO_STATS_EN
   logic [DROP_BITS-1:0] r_drop_count;
   logic [LVL_W-1:0]     r_hwm;

   // Clear beats a same-cycle drop; the counter saturates at all-ones.
   always_ff @(posedge clk) begin
      if (rst || stats_clear) begin
         r_drop_count <= '0;
      end else if (w_drop && (r_drop_count != '1)) begin
         r_drop_count <= r_drop_count + 1'b1;
      end
   end

   // Tracks the registered level, so it trails the level by one edge.
   always_ff @(posedge clk) begin
      if (rst || stats_clear) begin
         r_hwm <= '0;
      end else if (w_level > r_hwm) begin
         r_hwm <= w_level;
      end
   end

   assign drop_count = r_drop_count;
   assign hwm        = r_hwm;
`else
   logic w_stats_unused;
   assign w_stats_unused = stats_clear ^ w_drop;
   assign drop_count     = '0;
   assign hwm            = '0;
`endif

endmodule

// File: tb/tb_dvs_event_fifo.sv
// Purpose : randomized and directed stimulus against two FIFO instances
//           (back-pressure and lossy), checked cycle by cycle against
//           queue-based reference models.
module tb_dvs_event_fifo;

`ifdef DVS_FIFO_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   localparam int DEPTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, in_valid, in_pol, out_ready, flush, stats_clear;
   logic [8:0] in_x, in_y;
   logic [15:0] in_ts;

   logic        a_in_ready, a_out_valid, a_out_pol, a_afull;
   logic [8:0]  a_out_x, a_out_y;
   logic [15:0] a_out_ts, a_drop;
   logic [4:0]  a_level, a_hwm;

   logic        b_in_ready, b_out_valid, b_out_pol, b_afull;
   logic [8:0]  b_out_x, b_out_y;
   logic [15:0] b_out_ts;
   logic [3:0]  b_drop;
   logic [4:0]  b_level, b_hwm;

   dvs_event_fifo #(.DEPTH(DEPTH), .AFULL_THRESH(12), .LOSSY(0), .DROP_BITS(16)) u_bp (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
      .in_pol(in_pol), .in_ts(in_ts), .in_ready(a_in_ready),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_x(a_out_x),
      .out_y(a_out_y), .out_pol(a_out_pol), .out_ts(a_out_ts), .flush(flush),
      .level(a_level), .almost_full(a_afull), .stats_clear(stats_clear),
      .drop_count(a_drop), .hwm(a_hwm));

   dvs_event_fifo #(.DEPTH(DEPTH), .AFULL_THRESH(12), .LOSSY(1), .DROP_BITS(4)) u_lossy (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
      .in_pol(in_pol), .in_ts(in_ts), .in_ready(b_in_ready),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_x(b_out_x),
      .out_y(b_out_y), .out_pol(b_out_pol), .out_ts(b_out_ts), .flush(flush),
      .level(b_level), .almost_full(b_afull), .stats_clear(stats_clear),
      .drop_count(b_drop), .hwm(b_hwm));

   // Reference models: an event queue plus plain stats per instance.
   logic [34:0] qa[$];
   logic [34:0] qb[$];
   int drop_a, drop_b, hwm_a, hwm_b;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("bp.level",      64'(a_level),     64'(qa.size()));
      chk("bp.out_valid",  64'(a_out_valid), 64'(qa.size() > 0));
      chk("bp.in_ready",   64'(a_in_ready),  64'(qa.size() < DEPTH));
      chk("bp.afull",      64'(a_afull),     64'(qa.size() >= 12));
      chk("bp.drop",       64'(a_drop),      STATS ? 64'(drop_a) : 64'd0);
      chk("bp.hwm",        64'(a_hwm),       STATS ? 64'(hwm_a) : 64'd0);
      if (qa.size() > 0)
         chk("bp.head", 64'({a_out_x, a_out_y, a_out_pol, a_out_ts}), 64'(qa[0]));
      chk("lossy.level",     64'(b_level),     64'(qb.size()));
      chk("lossy.out_valid", 64'(b_out_valid), 64'(qb.size() > 0));
      chk("lossy.in_ready",  64'(b_in_ready),  64'd1);
      chk("lossy.afull",     64'(b_afull),     64'(qb.size() >= 12));
      chk("lossy.drop",      64'(b_drop),      STATS ? 64'(drop_b) : 64'd0);
      chk("lossy.hwm",       64'(b_hwm),       STATS ? 64'(hwm_b) : 64'd0);
      if (qb.size() > 0)
         chk("lossy.head", 64'({b_out_x, b_out_y, b_out_pol, b_out_ts}), 64'(qb[0]));
   endtask

   // Advance both models across one clock edge using the driven inputs.
   task automatic model_edge();
      logic [34:0] w;
      int la, lb;
      bit fa, fb;
      w  = {in_x, in_y, in_pol, in_ts};
      la = qa.size();
      lb = qb.size();
      fa = (la == DEPTH);
      fb = (lb == DEPTH);
      if (rst) begin
         qa.delete(); qb.delete();
         drop_a = 0; drop_b = 0; hwm_a = 0; hwm_b = 0;
      end else begin
         if (flush) begin
            qa.delete(); qb.delete();
         end else begin
            if (la > 0 && out_ready) void'(qa.pop_front());
            if (in_valid && !fa) qa.push_back(w);
            if (lb > 0 && out_ready) void'(qb.pop_front());
            if (in_valid && !fb) qb.push_back(w);
         end
         if (stats_clear) begin
            drop_a = 0; drop_b = 0; hwm_a = 0; hwm_b = 0;
         end else begin
            if (la > hwm_a) hwm_a = la;
            if (lb > hwm_b) hwm_b = lb;
            if (!flush && in_valid && fb && drop_b < 15) drop_b++;
         end
      end
   endtask

   // Called at a negedge: check current state, drive next inputs, step models.
   task automatic step(input bit v, input logic [8:0] x, input bit ordy,
                       input bit fl, input bit clr, input bit rs);
      check_all();
      in_valid    = v;
      in_x        = x;
      in_y        = 9'($urandom);
      in_pol      = 1'($urandom);
      in_ts       = 16'($urandom);
      out_ready   = ordy;
      flush       = fl;
      stats_clear = clr;
      rst         = rs;
      model_edge();
      @(negedge clk);
   endtask

   initial begin
      int pr;
      rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_pol = 1'b0; in_ts = '0;
      out_ready = 1'b0; flush = 1'b0; stats_clear = 1'b0;
      drop_a = 0; drop_b = 0; hwm_a = 0; hwm_b = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Basic ordering
      for (int i = 1; i <= 3; i++) step(1, 9'(i), 0, 0, 0, 0);
      chk("basic.level", 64'(a_level), 64'd3);
      chk("basic.head_x", 64'(a_out_x), 64'd1);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);
      chk("basic.empty", 64'(a_out_valid), 64'd0);

      // Fill, overflow, held event after a pop
      step(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 16; i++) step(1, 9'(16 + i), 0, 0, 0, 0);
      for (int i = 0; i < 5; i++)  step(1, 9'(100 + i), 0, 0, 0, 0);
      chk("ovf.bp_in_ready", 64'(a_in_ready), 64'd0);
      chk("ovf.bp_afull", 64'(a_afull), 64'd1);
      chk("ovf.lossy_level", 64'(b_level), 64'd16);
      chk("ovf.lossy_drop", 64'(b_drop), STATS ? 64'd5 : 64'd0);
      chk("ovf.lossy_hwm", 64'(b_hwm), STATS ? 64'd16 : 64'd0);
      step(1, 9'd200, 1, 0, 0, 0);
      step(1, 9'd200, 0, 0, 0, 0);
      for (int i = 0; i < 18; i++) step(0, 0, 1, 0, 0, 0);

      // Streaming across pointer wrap
      step(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 40; i++) begin
         step(1, 9'(300 + i), 1, 0, 0, 0);
         chk("stream.level_le1", 64'(b_level <= 5'd1), 64'd1);
      end
      step(0, 0, 1, 0, 0, 0);
      chk("stream.drop", 64'(b_drop), 64'd0);

      // Flush with level 7, then stats clear
      step(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 7; i++) step(1, 9'(400 + i), 0, 0, 0, 0);
      step(1, 9'd500, 0, 1, 0, 0);
      chk("flush.level", 64'(b_level), 64'd0);
      chk("flush.hwm", 64'(b_hwm), STATS ? 64'd7 : 64'd0);
      step(0, 0, 0, 0, 1, 0);
      chk("clear.hwm", 64'(b_hwm), 64'd0);

      // Randomized phases with varying consumer throughput
      for (int c = 0; c < 20; c++) begin
         pr = $urandom_range(10, 90);
         for (int i = 0; i < 100; i++)
            step($urandom_range(0, 99) < 70, 9'($urandom),
                 $urandom_range(0, 99) < pr, $urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 2, $urandom_range(0, 499) == 0);
      end
      check_all();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
